// File: rtl/pong_frame_scanout.sv
// Pong frame buffer sink: 160x120x3 pixel store written by plot strobes,
// scanned out as 640x480 VGA with 4x4 pixel replication, plus a hardware clear sweep.
module pong_frame_scanout #(
  parameter int         H_ACTIVE  = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_ACTIVE  = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic       plot,
  input  logic       clear,
  output logic       clear_busy,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);
  localparam int          FB_WORDS = 160 * 120;
  localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [14:0] CLR_LAST = 15'(FB_WORDS - 1);

  typedef enum logic {IDLE, SWEEP} clr_state_t;

  clr_state_t  state_reg, state_next;
  logic [14:0] clr_addr_reg, clr_addr_next;

  logic [2:0]  mem [0:FB_WORDS-1];
  logic [2:0]  rd_data_reg;
  logic        vga_clk_reg;
  logic        pix_en;
  logic [9:0]  h_cnt_reg, v_cnt_reg;
  logic        active, hs_now, vs_now, first_now;
  logic [14:0] rd_addr, wr_addr;
  logic [2:0]  wr_data;
  logic        wr_en, plot_ok;
  logic        d_active_reg, d_hs_reg, d_vs_reg, d_first_reg;
  logic        hs_reg, vs_reg, blank_n_reg, frame_start_reg;
  logic [2:0]  rgb_reg;

  // row*160 + col as (row<<7) + (row<<5) + col
  function automatic logic [14:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    return {1'b0, row, 7'b0} + {3'b0, row, 5'b0} + {7'b0, col};
  endfunction

  assign pix_en = vga_clk_reg;

  always_ff @(posedge clk) begin
    if (reset) vga_clk_reg <= 1'b0;
    else       vga_clk_reg <= ~vga_clk_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (pix_en) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 10'd1;
      end
    end
  end

  assign active    = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hs_now    = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
  assign vs_now    = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
  assign first_now = (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
  // Blanking-region counts would index past the buffer, so park the read on 0.
  assign rd_addr   = active ? fb_addr(v_cnt_reg[8:2], h_cnt_reg[9:2]) : '0;

  assign plot_ok = plot && (x_in < 8'd160) && (y_in < 7'd120) && (state_reg == IDLE);
  assign wr_en   = !reset && (plot_ok || (state_reg == SWEEP));
  assign wr_addr = (state_reg == SWEEP) ? clr_addr_reg : fb_addr(y_in, x_in);
  assign wr_data = (state_reg == SWEEP) ? BG_COLOUR : colour_in;

  // Read-before-write: a same-address read in the write clk sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[wr_addr] <= wr_data;
    if (pix_en) rd_data_reg  <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_active_reg    <= 1'b0;
      d_hs_reg        <= 1'b1;
      d_vs_reg        <= 1'b1;
      d_first_reg     <= 1'b0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      blank_n_reg     <= 1'b0;
      rgb_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= pix_en && d_first_reg;
      if (pix_en) begin
        d_active_reg <= active;
        d_hs_reg     <= hs_now;
        d_vs_reg     <= vs_now;
        d_first_reg  <= first_now;
        hs_reg       <= d_hs_reg;
        vs_reg       <= d_vs_reg;
        blank_n_reg  <= d_active_reg;
        rgb_reg      <= d_active_reg ? rd_data_reg : 3'b000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      IDLE: begin
        if (clear) begin
          state_next    = SWEEP;
          clr_addr_next = '0;
        end
      end
      SWEEP: begin
        if (clr_addr_reg == CLR_LAST) begin
          state_next    = IDLE;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr_reg + 15'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clear_busy  = (state_reg == SWEEP);
  assign frame_start = frame_start_reg;
  assign vga_clk     = vga_clk_reg;
  assign vga_hs      = hs_reg;
  assign vga_vs      = vs_reg;
  assign vga_blank_n = blank_n_reg;
  assign vga_r       = {8{rgb_reg[2]}};
  assign vga_g       = {8{rgb_reg[1]}};
  assign vga_b       = {8{rgb_reg[0]}};

endmodule

// File: tb/tb_pong_frame_scanout.sv
// Scoreboard bench for pong_frame_scanout with a shortened raster so whole frames fit the run.
module tb_pong_frame_scanout;
  localparam int         H_ACTIVE = 176, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int         V_ACTIVE = 32,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int         FRAME_CLKS = 2 * H_TOTAL * V_TOTAL;
  localparam int         FB_WORDS = 19200;
  localparam logic [2:0] BG = 3'b010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic       plot = 1'b0;
  logic       clear = 1'b0;
  logic       clear_busy, frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;

  pong_frame_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .plot(plot), .clear(clear), .clear_busy(clear_busy), .frame_start(frame_start),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #10 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       known;
    logic [2:0] rgb;
    logic       blank_n;
    logic       hs;
    logic       vs;
    logic       first;
  } pix_t;

  // bit 3 flags a word whose contents the bench cannot predict
  logic [3:0] model_mem [FB_WORDS];
  pix_t       exp_q [$];
  logic       m_vga_clk = 1'b0;
  int         m_h = 0, m_v = 0, m_clr = 0;
  logic       m_busy = 1'b0;

  initial for (int i = 0; i < FB_WORDS; i++) model_mem[i] = 4'b1000;

  always @(posedge clk) begin : monitor
    pix_t e, got_e;
    logic pix, popped, in_reset;
    int   a;
    popped   = 1'b0;
    pix      = 1'b0;
    in_reset = reset;
    got_e    = '0;
    if (reset) begin
      m_vga_clk = 1'b0;
      m_h = 0; m_v = 0; m_busy = 1'b0; m_clr = 0;
      exp_q.delete();
    end else begin
      pix = m_vga_clk;
      m_vga_clk = ~m_vga_clk;
      if (pix) begin
        e.blank_n = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
        e.hs      = !((m_h >= H_ACTIVE + H_FP) && (m_h < H_ACTIVE + H_FP + H_SYNC));
        e.vs      = !((m_v >= V_ACTIVE + V_FP) && (m_v < V_ACTIVE + V_FP + V_SYNC));
        e.first   = (m_h == 0) && (m_v == 0);
        if (e.blank_n) begin
          a       = (m_v / 4) * 160 + (m_h / 4);
          e.known = !model_mem[a][3];
          e.rgb   = model_mem[a][2:0];
        end else begin
          e.known = 1'b1;
          e.rgb   = 3'b000;
        end
        exp_q.push_back(e);
        if (exp_q.size() > 1) begin
          got_e  = exp_q.pop_front();
          popped = 1'b1;
        end
        if (m_h == H_TOTAL - 1) begin
          m_h = 0;
          m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
        end else begin
          m_h++;
        end
      end
      // memory and clear model, applied after the read above (old data on collision)
      if (m_busy) begin
        model_mem[m_clr] = {1'b0, BG};
        if (m_clr == FB_WORDS - 1) begin
          m_busy = 1'b0;
          m_clr  = 0;
        end else begin
          m_clr++;
        end
      end else begin
        if (plot && (x_in < 8'd160) && (y_in < 7'd120))
          model_mem[int'(y_in) * 160 + int'(x_in)] = {1'b0, colour_in};
        if (clear) begin
          m_busy = 1'b1;
          m_clr  = 0;
        end
      end
    end
    #1;
    if (in_reset) begin
      check_eq("rst_vga_clk", vga_clk, 0);
      check_eq("rst_hs", vga_hs, 1);
      check_eq("rst_vs", vga_vs, 1);
      check_eq("rst_blank_n", vga_blank_n, 0);
      check_eq("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      check_eq("rst_frame_start", frame_start, 0);
      check_eq("rst_clear_busy", clear_busy, 0);
    end else begin
      check_eq("vga_clk", vga_clk, m_vga_clk);
      check_eq("clear_busy", clear_busy, m_busy);
      if (popped) begin
        check_eq("hs", vga_hs, got_e.hs);
        check_eq("vs", vga_vs, got_e.vs);
        check_eq("blank_n", vga_blank_n, got_e.blank_n);
        check_eq("frame_start", frame_start, got_e.first);
        if (got_e.known)
          check_eq("rgb", {vga_r, vga_g, vga_b},
                   {{8{got_e.rgb[2]}}, {8{got_e.rgb[1]}}, {8{got_e.rgb[0]}}});
      end else if (pix) begin
        check_eq("pre_hs", vga_hs, 1);
        check_eq("pre_blank_n", vga_blank_n, 0);
        check_eq("pre_frame_start", frame_start, 0);
      end else begin
        check_eq("frame_start_idle", frame_start, 0);
      end
    end
  end

  task automatic plot_px(input int x, input int y, input logic [2:0] c);
    x_in      = 8'(x);
    y_in      = 7'(y);
    colour_in = c;
    plot      = 1'b1;
    @(negedge clk);
    plot      = 1'b0;
  endtask

  initial begin : stimulus
    int   n;
    logic found;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Full clear; mid-sweep a retrigger and a plot to an already-swept word are both ignored.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n = 0;
    while (clear_busy && n < 30000) begin
      n++;
      if (n == 5000) begin
        clear = 1'b1;
        x_in = 8'd2; y_in = 7'd0; colour_in = 3'b111; plot = 1'b1;
      end else begin
        clear = 1'b0;
        plot  = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("sweep_len", n, 19200);
    $display("clear sweep: busy for %0d clks", n);

    // In-range plots plus out-of-range ones that would alias visible words if accepted.
    plot_px(5, 3, 3'b100);
    plot_px(160, 1, 3'b111);
    plot_px(200, 0, 3'b111);
    plot_px(10, 120, 3'b111);
    plot_px(39, 6, 3'b001);
    plot_px(40, 6, 3'b101);
    plot_px(41, 6, 3'b110);
    plot_px(43, 7, 3'b011);
    plot_px(0, 1, 3'b111);
    $display("plots issued: 9 writes (3 out of range)");

    // Collide a plot at (0,0) with the scan read of address 0.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      if (m_vga_clk && m_h == 0 && m_v == 0) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("collision_sync", found, 1);
    plot_px(0, 0, 3'b111);
    $display("collision plot at (0,0) issued at %0t", $time);
    repeat (FRAME_CLKS + 16) @(negedge clk);
    $display("frame after plots scanned");

    // Reset lands on the clk that would write address 1000.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_busy && m_clr == 1000) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("abort_sync", found, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", clear_busy, 0);
    $display("sweep aborted by reset at address 1000");
    repeat (FRAME_CLKS + 16) @(negedge clk);
    $display("frame after aborted sweep scanned");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pong_frame_scanout.md
Name: pong_frame_scanout

Overview:
- Sink end of the pixel-plot interface used by the Pong drawing logic.
- Accepts single-pixel writes (x, y, colour, plot) into an internal 160x120, 3-bit frame buffer.
- Scans the buffer out as 640x480 VGA with each stored pixel replicated 4x4.
- Also provides a hardware clear sweep, so game logic can wipe the screen without plotting 19200 pixels.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
BG_COLOUR, 3'b000, colour written by a clear sweep

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
x_in  in  8  plot column, 0..159 valid
y_in  in  7  plot row, 0..119 valid
colour_in  in  3  {r,g,b} plot colour
plot  in  1  write strobe, one pixel per clk it is high
clear  in  1  start clear sweep (level sampled each clk)
clear_busy  out  1  high while a clear sweep runs
frame_start  out  1  one-clk pulse at start of each frame
vga_clk  out  1  25 MHz pixel clock
vga_hs  out  1  hsync, active low
vga_vs  out  1  vsync, active low
vga_blank_n  out  1  high in active video
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue

Behaviour:
- Reset values:
  - vga_clk=0, vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0.
  - frame_start=0, clear_busy=0.
  - h_cnt=0, v_cnt=0, clear address=0.
  - Memory contents are not reset.
- Pixel clocking:
  - vga_clk is a register that toggles every clk.
  - pix_en = (vga_clk==1).
  - All scan counters and VGA outputs update only on pix_en clks, so outputs change when vga_clk falls and are stable at its rising edge.
- Counters:
  - h_cnt counts 0..799 (sum of H params minus 1) on pix_en, then wraps to 0.
  - v_cnt increments when h_cnt wraps and counts 0..524, then wraps to 0.
- Active region: h_cnt<640 and v_cnt<480.
  - hs low for h_cnt 656..751.
  - vs low for v_cnt 490..491.
- Read address = (v_cnt>>2)*160 + (h_cnt>>2).
  - Computed with shifts/adds as (r<<7)+(r<<5)+c.
  - 15-bit address.
- Pipeline:
  - On a pix_en clk, memory read is issued and active/hs/vs are registered into a delay stage.
  - Read data is valid the next clk.
  - On the following pix_en clk, outputs load the read data and the delayed sync/blank.
  - Outputs therefore lag the counters by exactly one pixel period (2 clk).
- RGB:
  - In active video, r={8{c[2]}}, g={8{c[1]}}, b={8{c[0]}}.
  - Outside active video, rgb=0 and blank_n=0.
- frame_start: one-clk pulse on the pix_en clk at which the delayed stage shows h=0, v=0 (aligned with the first active output pixel).
- Plot writes:
  - Taken on any clk with plot=1, x_in<160, y_in<120, and clear_busy=0.
  - Write address = y_in*160 + x_in.
  - Out-of-range or busy-time plots are silently dropped.
  - No backpressure; back-to-back writes are allowed every clk.
- Read/write collision: a same-address read and write in one clk returns old data; the new data appears from the next read.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clear=1; clear_busy goes high the next clk.
  - SWEEP writes BG_COLOUR to address 0..19199, one per clk.
  - After writing 19199, the FSM returns to IDLE and clear_busy falls the next clk.
  - The sweep takes 19200 clks.
  - clear asserted during SWEEP is ignored (no restart).
  - Scan-out continues during a sweep.
- Reset mid-sweep aborts the sweep immediately. Memory is left partially cleared.

Test Plan:
1. Release reset, no writes -> vga_clk toggles each clk. hs low for 96 pixel periods per 800. vs low on 2 of every 525 lines. blank_n high 640 of every 800 pixel periods.
2. Plot x=5,y=3,colour=3'b100 -> output pixels h=20..23, lines v=12..15 show r=8'hFF, g=0, b=0. Neighbouring pixels show the prior content.
3. Plot x=160,y=10 and x=10,y=120 -> no memory change. A readback at (0,10) and (10,0) is unchanged.
4. clear pulse with BG_COLOUR=3'b010 -> clear_busy high for 19200 clks. A plot during the sweep is dropped. After the sweep, the whole active frame is g=8'hFF.
5. reset at sweep clk 1000 -> clear_busy=0 next clk. Addresses 0..999 hold BG_COLOUR; address 19199 is unchanged.
6. Plot (0,0) in the same clk the scan reads address 0 -> that pixel shows the old colour. The next line reading address 0 shows the new colour.
